mul_dense_stream: RTL



---
 rtl/mul_dense_stream.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mul_dense_stream.sv
// Streaming dense NxN matrix multiplier: load A/B element pairs, then compute C = A x B
// with LANES parallel MACs, emitting LANES results per beat under valid/ready backpressure.
module mul_dense_stream #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int LANES  = 2,
    parameter int SIGNED = 1,
    localparam int ACC_W = 2*DATA_W + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        a_data,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   out_data,
    output logic                     out_last,
    output logic                     busy
);
    localparam int IDX_W   = $clog2(N*N);
    localparam int CW      = $clog2(N);
    localparam int GROUPS  = N / LANES;
    localparam int JW      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int EXT_W   = ACC_W - 2*DATA_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N*N - 1);
    localparam logic [CW-1:0]    K_LAST   = CW'(N - 1);
    localparam logic [JW-1:0]    JG_LAST  = JW'(GROUPS - 1);
    localparam logic             SGN      = (SIGNED != 0);

    typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CW-1:0]     i_reg;
    logic [CW-1:0]     k_reg;
    logic [JW-1:0]     jg_reg;
    logic [ACC_W-1:0]  acc_reg [LANES];
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] a_mem [N*N];
    logic [DATA_W-1:0] b_mem [N*N];

    logic [IDX_W-1:0]  a_addr;
    logic [DATA_W-1:0] a_val;
    logic [ACC_W-1:0]  prod_ext [LANES];

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

    // Operand storage is read combinationally so each MAC cycle consumes one k step.
    always_ff @(posedge clk) begin
        if (state_reg == LOAD && in_valid) begin
            a_mem[idx_reg] <= a_data;
            b_mem[idx_reg] <= b_data;
        end
    end

    assign a_addr = i_reg * IDX_W'(N) + IDX_W'(k_reg);
    assign a_val  = a_mem[a_addr];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [IDX_W-1:0]    b_addr;
            logic [DATA_W-1:0]   b_val;
            logic [2*DATA_W-1:0] a_ext;
            logic [2*DATA_W-1:0] b_ext;
            logic [2*DATA_W-1:0] prod;

            assign b_addr = k_reg * IDX_W'(N) + jg_reg * IDX_W'(LANES) + IDX_W'(gi);
            assign b_val  = b_mem[b_addr];
            // Low 2*DATA_W bits of the product of extended operands equal the exact product.
            assign a_ext  = {{DATA_W{SGN & a_val[DATA_W-1]}}, a_val};
            assign b_ext  = {{DATA_W{SGN & b_val[DATA_W-1]}}, b_val};
            assign prod   = a_ext * b_ext;
            assign prod_ext[gi] = {{EXT_W{SGN & prod[2*DATA_W-1]}}, prod};
            assign out_data[gi*ACC_W +: ACC_W] = acc_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= LOAD;
            idx_reg       <= '0;
            i_reg         <= '0;
            k_reg         <= '0;
            jg_reg        <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            for (int l = 0; l < LANES; l++) acc_reg[l] <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_valid) begin
                        idx_reg <= idx_reg + IDX_W'(1);
                        if (idx_reg == IDX_LAST) begin
                            state_reg    <= MAC;
                            idx_reg      <= '0;
                            i_reg        <= '0;
                            jg_reg       <= '0;
                            k_reg        <= '0;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                            for (int l = 0; l < LANES; l++) acc_reg[l] <= '0;
                        end
                    end
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++) acc_reg[l] <= acc_reg[l] + prod_ext[l];
                    k_reg <= k_reg + CW'(1);
                    if (k_reg == K_LAST) begin
                        k_reg         <= '0;
                        state_reg     <= OUT;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (i_reg == K_LAST) && (jg_reg == JG_LAST);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (out_last_reg) begin
                            state_reg    <= LOAD;
                            idx_reg      <= '0;
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b0;
                        end else begin
                            if (jg_reg == JG_LAST) begin
                                jg_reg <= '0;
                                i_reg  <= i_reg + CW'(1);
                            end else begin
                                jg_reg <= jg_reg + JW'(1);
                            end
                            k_reg     <= '0;
                            state_reg <= MAC;
                            for (int l = 0; l < LANES; l++) acc_reg[l] <= '0;
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end
endmodule
